ecc_link_tx: RTL and testbench

Serial transmitter for the 16-bit diagonal/parity ECC codeword. Accepts 16-bit data words over a valid/ready handshake and computes the 18 check bits to form a 34-bit codeword. Frames the codeword with start and stop bits and shifts it out LSB-first on a single line. It is the sending end of the link whose far end decodes and corrects the codeword.

---
 rtl/ecc_link_tx.sv | 152 +++++++++++++++
 tb/tb_ecc_link_tx.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ecc_link_tx.sv
// ecc_link_tx: encodes 16-bit words into the 34-bit diagonal/parity ECC codeword and sends it
// framed (start, LSB-first codeword, stop) on tx_line. Define ECC_TX_PARITY_EN for a trailing even-parity bit.
module ecc_link_tx #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        tx_line,
  output logic        busy,
  output logic        frame_done
);

`ifdef ECC_TX_PARITY_EN
  localparam int NBITS = 35;
`else
  localparam int NBITS = 34;
`endif
  localparam logic [15:0] CNT_LAST = 16'(CLKS_PER_BIT - 1);
  localparam logic [5:0]  IDX_LAST = 6'(NBITS - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t           state_q, state_d;
  logic [15:0]      cnt_q, cnt_d;
  logic [5:0]       idx_q, idx_d;
  logic [15:0]      hold_q, hold_d;
  logic             hold_full_q, hold_full_d;
  logic [NBITS-1:0] shift_q, shift_d;
  logic             tx_line_q, tx_line_d;
  logic             frame_done_q, frame_done_d;
  logic             bit_end;
  logic             load;
  logic [33:0]      cw;
  logic [NBITS-1:0] frame_word;

  // Group vectors are indexed [4:1] so g[i] matches the group bit numbering.
  function automatic logic [33:0] encode(input logic [15:0] x);
    logic [4:1] a, b, c, d, p;
    logic [6:1] dg;
    a = {x[0],  x[1],  x[2],  x[3]};
    b = {x[4],  x[5],  x[6],  x[7]};
    c = {x[8],  x[9],  x[10], x[11]};
    d = {x[12], x[13], x[14], x[15]};
    p = a ^ b ^ c ^ d;
    dg[1] = a[1] ^ b[2] ^ c[1] ^ d[2];
    dg[2] = a[2] ^ b[1] ^ c[2] ^ d[1];
    dg[3] = a[3] ^ b[4] ^ c[3] ^ d[4];
    dg[4] = a[4] ^ b[3] ^ c[4] ^ d[3];
    dg[5] = a[2] ^ b[3] ^ c[2] ^ d[3];
    dg[6] = a[3] ^ b[2] ^ c[3] ^ d[2];
    return {dg[6], dg[5], dg[4], p[4], d[1] ^ d[3], d[2] ^ d[4],
            dg[3], p[3], c[1] ^ c[3], c[2] ^ c[4],
            dg[2], p[2], b[1] ^ b[3], b[2] ^ b[4],
            dg[1], p[1], a[1] ^ a[3], a[2] ^ a[4], x};
  endfunction

  assign cw = encode(hold_q);
`ifdef ECC_TX_PARITY_EN
  assign frame_word = {^cw, cw};
`else
  assign frame_word = cw;
`endif

  assign bit_end = (cnt_q == CNT_LAST);
  // Shifter is (re)loaded whenever a new frame begins, from IDLE or directly out of STOP.
  assign load = hold_full_q && ((state_q == IDLE) || (state_q == STOP && bit_end));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      idx_q        <= '0;
      hold_q       <= '0;
      hold_full_q  <= 1'b0;
      shift_q      <= '0;
      tx_line_q    <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      hold_q       <= hold_d;
      hold_full_q  <= hold_full_d;
      shift_q      <= shift_d;
      tx_line_q    <= tx_line_d;
      frame_done_q <= frame_done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 16'd1;
    idx_d   = idx_q;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (hold_full_q) state_d = START;
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          cnt_d   = '0;
          idx_d   = '0;
        end
      end
      DATA: begin
        if (bit_end) begin
          cnt_d = '0;
          if (idx_q == IDX_LAST) state_d = STOP;
          else                   idx_d   = idx_q + 6'd1;
        end
      end
      STOP: begin
        if (bit_end) begin
          cnt_d   = '0;
          state_d = hold_full_q ? START : IDLE;
        end
      end
    endcase
  end

  // tx_line is registered from the next state so the line changes on the same edge as the state.
  always_comb begin
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    shift_d     = shift_q;
    if (load) begin
      shift_d     = frame_word;
      hold_full_d = 1'b0;
    end else if (in_valid && !hold_full_q) begin
      hold_d      = in_data;
      hold_full_d = 1'b1;
    end
    if (state_q == DATA && bit_end) shift_d = shift_q >> 1;

    unique case (state_d)
      START:   tx_line_d = 1'b0;
      DATA:    tx_line_d = shift_d[0];
      default: tx_line_d = 1'b1;
    endcase
    frame_done_d = (state_d == STOP) && (cnt_d == CNT_LAST);
  end

  assign in_ready   = !hold_full_q;
  assign tx_line    = tx_line_q;
  assign busy       = (state_q != IDLE);
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_ecc_link_tx.sv
// Scoreboard bench for ecc_link_tx: two lanes (CLKS_PER_BIT 1 and 4) with random and directed words.
`timescale 1ns/1ps
module tb_ecc_link_tx;

`ifdef ECC_TX_PARITY_EN
  localparam int NB = 35;
`else
  localparam int NB = 34;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int lanes_done = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // Reference frame payload: codeword built from the group/diagonal rules with plain integer sums.
  function automatic logic [NB-1:0] ref_frame(input logic [15:0] x);
    int g[4][1:4];
    int p[1:4];
    int dg[1:6];
    int ones;
    int pos;
    logic [63:0] cw;
    for (int j = 0; j < 4; j++)
      for (int i = 1; i <= 4; i++)
        g[j][i] = int'((x >> (4 * j + 4 - i)) & 16'h1);
    for (int i = 1; i <= 4; i++) p[i] = (g[0][i] + g[1][i] + g[2][i] + g[3][i]) % 2;
    dg[1] = (g[0][1] + g[1][2] + g[2][1] + g[3][2]) % 2;
    dg[2] = (g[0][2] + g[1][1] + g[2][2] + g[3][1]) % 2;
    dg[3] = (g[0][3] + g[1][4] + g[2][3] + g[3][4]) % 2;
    dg[4] = (g[0][4] + g[1][3] + g[2][4] + g[3][3]) % 2;
    dg[5] = (g[0][2] + g[1][3] + g[2][2] + g[3][3]) % 2;
    dg[6] = (g[0][3] + g[1][2] + g[2][3] + g[3][2]) % 2;
    cw  = 64'(x);
    pos = 16;
    for (int j = 0; j < 4; j++) begin
      cw  = cw + (64'((g[j][2] + g[j][4]) % 2) << pos);
      cw  = cw + (64'((g[j][1] + g[j][3]) % 2) << (pos + 1));
      cw  = cw + (64'(p[j + 1]) << (pos + 2));
      cw  = cw + (64'(dg[j + 1]) << (pos + 3));
      pos = pos + 4;
    end
    cw = cw + (64'(dg[5]) << 32) + (64'(dg[6]) << 33);
    ones = 0;
    for (int i = 0; i < 34; i++) ones += int'((cw >> i) & 64'h1);
    if (NB == 35) cw = cw + (64'(ones % 2) << 34);
    return cw[NB-1:0];
  endfunction

  for (genvar gi = 0; gi < 2; gi++) begin : g_lane
    localparam int CPB = (gi == 0) ? 1 : 4;
    localparam int FL  = (NB + 2) * CPB;

    logic        rst_n;
    logic [15:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic        tx_line;
    logic        busy;
    logic        frame_done;

    logic [NB-1:0] exp_q[$];
    bit in_frame = 1'b0;
    int k      = 0;
    int gap    = 0;
    int frames = 0;
    int b2b    = 0;

    ecc_link_tx #(.CLKS_PER_BIT(CPB)) u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_data    (in_data),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .tx_line    (tx_line),
      .busy       (busy),
      .frame_done (frame_done)
    );

    function automatic string nm(input string s);
      return $sformatf("cpb%0d_%s", CPB, s);
    endfunction

    // Monitor: reassembles each frame from the line and checks it against the scoreboard head.
    initial begin : monitor
      logic [NB-1:0] got;
      logic [NB-1:0] exp_w;
      int bad;
      int fd_hits;
      int fd_at;
      int bitn;
      got = '0; bad = 0; fd_hits = 0; fd_at = -1;
      forever begin
        @(negedge clk);
        if (rst_n !== 1'b1) begin
          in_frame = 1'b0;
          gap      = 0;
        end else begin
          if (!in_frame) begin
            if (frame_done !== 1'b0) check(nm("frame_done_outside_frame"), 64'(frame_done), 64'd0);
            if (tx_line === 1'b0) begin
              in_frame = 1'b1;
              k = 0; got = '0; bad = 0; fd_hits = 0; fd_at = -1;
              if (gap == 0 && frames > 0) b2b++;
              gap = 0;
            end else begin
              gap++;
            end
          end
          if (in_frame) begin
            bitn = k / CPB;
            if (busy !== 1'b1) bad++;
            if (frame_done === 1'b1) begin
              fd_hits++;
              fd_at = k;
            end
            if (bitn == 0) begin
              if (tx_line !== 1'b0) bad++;
            end else if (bitn <= NB) begin
              if (k % CPB == 0) got = {tx_line, got[NB-1:1]};
              else if (got[NB-1] !== tx_line) bad++;
            end else if (tx_line !== 1'b1) begin
              bad++;
            end
            k++;
            if (k == FL) begin
              in_frame = 1'b0;
              frames++;
              check(nm("frame_expected"), 64'(exp_q.size() != 0), 64'd1);
              if (exp_q.size() != 0) begin
                exp_w = exp_q.pop_front();
                check(nm("frame_bits"), 64'(got), 64'(exp_w));
              end
              check(nm("frame_shape_errs"), 64'(bad), 64'd0);
              check(nm("frame_done_count"), 64'(fd_hits), 64'd1);
              check(nm("frame_done_pos"), 64'(fd_at), 64'(FL - 1));
            end
          end
        end
      end
    end

    // Offer w from a negedge; returns at the negedge following the accepting edge.
    task automatic send(input logic [15:0] w);
      int n;
      n = 0;
      in_data  = w;
      in_valid = 1'b1;
      while (in_ready !== 1'b1 && n < 3000) begin
        @(negedge clk);
        n++;
      end
      if (n >= 3000) check(nm("accept_timeout"), 64'(in_ready), 64'd1);
      else exp_q.push_back(ref_frame(w));
      @(negedge clk);
      in_valid = 1'b0;
    endtask

    task automatic wait_idle();
      int n;
      n = 0;
      @(negedge clk);
      while (!(busy === 1'b0 && in_ready === 1'b1 && exp_q.size() == 0) && n < 6000) begin
        @(negedge clk);
        n++;
      end
      if (n >= 6000) check(nm("idle_timeout"), 64'(busy), 64'd0);
    endtask

    initial begin : stim
      logic [15:0] dir[4];
      int base;
      int n;
      dir = '{16'h8000, 16'hFFFF, 16'h0000, 16'h0002};
      rst_n = 1'b0; in_valid = 1'b0; in_data = '0;
      repeat (3) @(negedge clk);
      check(nm("rst_tx_line"),    64'(tx_line),    64'd1);
      check(nm("rst_in_ready"),   64'(in_ready),   64'd1);
      check(nm("rst_busy"),       64'(busy),       64'd0);
      check(nm("rst_frame_done"), 64'(frame_done), 64'd0);
      #2 rst_n = 1'b1;
      @(negedge clk);

      send(16'h0001);
      check(nm("e0_in_ready"), 64'(in_ready), 64'd0);
      check(nm("e0_tx_line"),  64'(tx_line),  64'd1);
      check(nm("e0_busy"),     64'(busy),     64'd0);
      @(negedge clk);
      check(nm("e1_tx_line"),  64'(tx_line),  64'd0);
      check(nm("e1_busy"),     64'(busy),     64'd1);
      check(nm("e1_in_ready"), 64'(in_ready), 64'd1);
      wait_idle();

      for (int i = 0; i < 4; i++) begin
        send(dir[i]);
        wait_idle();
      end

      base = b2b;
      for (int i = 0; i < 3; i++) send(16'($urandom));
      wait_idle();
      check(nm("back_to_back_frames"), 64'(b2b - base), 64'd2);

      for (int i = 0; i < 6; i++) begin
        send(16'($urandom));
        repeat ($urandom_range(0, 40 * CPB)) @(negedge clk);
      end
      wait_idle();

      // Reset during data bit 10 with a second word buffered; both must be discarded.
      send(16'($urandom));
      send(16'($urandom));
      n = 0;
      while (!(in_frame && (k / CPB) == 11) && n < 3000) begin
        @(negedge clk);
        n++;
      end
      check(nm("reached_bit10"), 64'(in_frame && (k / CPB) == 11), 64'd1);
      #2 rst_n = 1'b0;
      #1;
      check(nm("midrst_tx_line"),    64'(tx_line),    64'd1);
      check(nm("midrst_busy"),       64'(busy),       64'd0);
      check(nm("midrst_in_ready"),   64'(in_ready),   64'd1);
      check(nm("midrst_frame_done"), 64'(frame_done), 64'd0);
      @(negedge clk);
      exp_q.delete();
      #2 rst_n = 1'b1;
      base = frames;
      repeat (12 * CPB) @(negedge clk);
      check(nm("post_reset_quiet"), 64'(frames - base), 64'd0);
      send(16'($urandom));
      wait_idle();
      check(nm("post_reset_frames"), 64'(frames - base), 64'd1);

      lanes_done++;
    end
  end

  initial begin : finisher
    int n;
    n = 0;
    while (lanes_done < 2 && n < 60000) begin
      @(negedge clk);
      n++;
    end
    check("all_lanes_done", 64'(lanes_done), 64'd2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
